// File: rtl/slot_alloc_pkg.sv
// Shared types and helpers for the round-robin slot allocator.
package slot_alloc_pkg;

    localparam int unsigned SLOT_W    = 32;
    localparam int unsigned POP_MAX_W = 256;

    typedef logic [$clog2(SLOT_W)-1:0]   id_t;
    typedef logic [$clog2(SLOT_W+1)-1:0] cnt_t;

    // Number of set bits in a (zero-extended) vector.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_alloc_rr_clz.sv
// Circular left-most-zero finder: highest zero of x_i strictly below pos_i,
// else highest zero overall. Two-level radix tree over a doubled candidate vector.
module slot_alloc_rr_clz
    import slot_alloc_pkg::*;
#(
    parameter int unsigned W       = SLOT_W,
    parameter int unsigned RADIX_N = 4
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic [$clog2(W)-1:0] y_enc_o,
    output logic                 any_o
);

    localparam int unsigned IDW = $clog2(W);
    localparam int unsigned CW  = 2 * W;
    localparam int unsigned NG  = (CW + RADIX_N - 1) / RADIX_N;
    localparam int unsigned PW  = NG * RADIX_N;
    localparam int unsigned LW  = $clog2(RADIX_N);
    localparam int unsigned CIW = $clog2(PW) + 1;

    logic [W-1:0]   zero;
    logic [W-1:0]   below;
    logic [PW-1:0]  cand;
    logic [NG-1:0]  grp_any;
    logic [LW-1:0]  grp_idx [NG];
    logic [CIW-1:0] cidx;
    logic [CIW-1:0] y;
    logic           hit;

    // Upper half holds zeros below pos, so any hit there wins over the wrap half.
    always_comb begin
        zero  = ~x_i;
        below = '0;
        for (int unsigned i = 0; i < W; i++) begin
            below[i] = zero[i] && (IDW'(i) < pos_i);
        end
        cand = PW'({below, zero});
    end

    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            grp_any[g] = 1'b0;
            grp_idx[g] = '0;
            for (int unsigned k = 0; k < RADIX_N; k++) begin
                if (cand[g*RADIX_N + k]) begin
                    grp_any[g] = 1'b1;
                    grp_idx[g] = LW'(k);
                end
            end
        end
    end

    always_comb begin
        hit  = 1'b0;
        cidx = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (grp_any[g]) begin
                hit  = 1'b1;
                cidx = CIW'(g * RADIX_N) + CIW'(grp_idx[g]);
            end
        end
        if (cidx >= CIW'(W)) begin
            y = cidx - CIW'(W);
        end else begin
            y = cidx;
        end
    end

    assign y_enc_o = IDW'(y);
    assign any_o   = hit;

endmodule

// File: rtl/slot_alloc_rr.sv
// Round-robin free-slot allocator: offers the next free slot below the last
// grant (descending, circular) on a valid/ready channel; slots return via free.
module slot_alloc_rr
    import slot_alloc_pkg::*;
#(
    parameter int unsigned W       = SLOT_W,
    parameter int unsigned RADIX_N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   alloc_vld_o,
    input  logic                   alloc_rdy_i,
    output logic [$clog2(W)-1:0]   alloc_id_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_id_i,
    output logic [W-1:0]           busy_o,
    output logic [$clog2(W+1)-1:0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int unsigned IDW  = $clog2(W);
    localparam int unsigned CNTW = $clog2(W+1);

    logic [W-1:0]    busy_q, busy_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            vld_q, vld_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            full_q, empty_q, err_q, err_d;

    logic [IDW-1:0]  srch_id;
    logic            srch_any;
    logic            load_c;
    logic            free_ok_c;

    slot_alloc_rr_clz #(
        .W       (W),
        .RADIX_N (RADIX_N)
    ) u_clz (
        .x_i     (busy_q),
        .pos_i   (ptr_q),
        .y_enc_o (srch_id),
        .any_o   (srch_any)
    );

    // A free is legal only for a held slot that is not the one still on offer.
    always_comb begin
        load_c    = (!vld_q || alloc_rdy_i) && srch_any;
        free_ok_c = free_vld_i
                 && ({1'b0, free_id_i} < (IDW+1)'(W))
                 && busy_q[free_id_i]
                 && !(vld_q && (free_id_i == id_q));
    end

    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        id_d   = id_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        err_d  = err_q || (free_vld_i && !free_ok_c);

        if (free_ok_c) begin
            busy_d[free_id_i] = 1'b0;
        end
        if (load_c) begin
            busy_d[srch_id] = 1'b1;
            ptr_d           = srch_id;
            id_d            = srch_id;
            vld_d           = 1'b1;
        end else if (vld_q && alloc_rdy_i) begin
            vld_d = 1'b0;
        end

        unique case ({load_c, free_ok_c})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNTW'(W));
            empty_q <= (cnt_d == '0);
            err_q   <= err_d;
        end
    end

    assign alloc_vld_o = vld_q;
    assign alloc_id_o  = id_q;
    assign busy_o      = busy_q;
    assign count_o     = cnt_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign err_o       = err_q;

endmodule
